// File: rtl/pcs_40g_pkg.sv
// pcs_40g_pkg -- shared definitions for the 40GBASE-R receive PCS blocks.
//   am_state_t        : alignment-marker lock states
//   AM_SYNC_HEAD      : sync header carried by every alignment marker
//   AM_MISMATCH_LIMIT : consecutive bad marker slots that drop lock
//   AM_LANE_PAT       : {M0,M1,M2} per PCS lane, M0 in bits [23:16]
//   bip8_contrib()    : one block's contribution to the lane BIP-8
package pcs_40g_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_WAIT_2ND = 2'd1,
    ST_LOCKED   = 2'd2
  } am_state_t;

  localparam logic [1:0] AM_SYNC_HEAD      = 2'b10;
  localparam int         AM_MISMATCH_LIMIT = 4;
  localparam int         AM_NUM_LANES      = 4;

  // Index 0 is lane 0; each entry holds {M0, M1, M2}.
  localparam logic [AM_NUM_LANES-1:0][23:0] AM_LANE_PAT = {
    24'hA2793D,   // lane 3
    24'hC5659B,   // lane 2
    24'hF0C4E6,   // lane 1
    24'h907647    // lane 0
  };

  // Bit j is the XOR of bit j of all eight payload bytes; the sync header
  // bits fold into BIP bits 3 (head[0]) and 4 (head[1]).
  function automatic logic [7:0] bip8_contrib(input logic [1:0]  head,
                                              input logic [63:0] data);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < 8; k++) begin
      acc = acc ^ data[8*k +: 8];
    end
    acc = acc ^ {3'b000, head[1], head[0], 3'b000};
    return acc;
  endfunction

endpackage

// File: rtl/pcs_40g_am_match.sv
// pcs_40g_am_match -- combinational alignment-marker pattern matcher.
//   i_valid : block present
//   i_head  : sync header of the block
//   i_key   : payload bytes {0,1,2}, byte 0 in [23:16]
//   i_inv   : payload bytes {4,5,6}, byte 4 in [23:16]
//   o_match : block is a marker of some PCS lane
//   o_lane  : lane number of the matching marker (0 when no match)
module pcs_40g_am_match
  import pcs_40g_pkg::*;
(
  input  logic        i_valid,
  input  logic [1:0]  i_head,
  input  logic [23:0] i_key,
  input  logic [23:0] i_inv,
  output logic        o_match,
  output logic [1:0]  o_lane
);

  // Compare against every lane; the four patterns are distinct, so at most one hits.
  always_comb begin
    o_match = 1'b0;
    o_lane  = 2'd0;
    for (int l = 0; l < AM_NUM_LANES; l++) begin
      if (i_valid && (i_head == AM_SYNC_HEAD) &&
          (i_key == AM_LANE_PAT[l]) && (i_inv == ~AM_LANE_PAT[l])) begin
        o_match = 1'b1;
        o_lane  = 2'(l);
      end else begin
        o_match = o_match;
      end
    end
  end

endmodule

// File: rtl/pcs_40g_rx_am_lock.sv
// pcs_40g_rx_am_lock -- per-lane alignment marker lock for the 40G RX PCS.
// Passes 66b blocks through with one register stage and tracks marker
// cadence: lock after two markers of the same lane AM_PERIOD valid blocks
// apart, drop after four consecutive bad marker slots or loss of block lock.
// Optional BIP-8 checking is compiled in with macro PCS_40G_RX_BIP_EN.
//   clk, nreset   : clock, synchronous active-high reset
//   valid_i/head_i/data_i : input block; block_lock_i : upstream block lock
//   valid_o/head_o/data_o : block delayed one cycle
//   am_v_o        : output block is a marker slot while locked
//   am_lock_o     : marker lock; lane_id_o : locked PCS lane
//   bip_err_o     : BIP-8 mismatch pulse (PCS_40G_RX_BIP_EN only)
module pcs_40g_rx_am_lock
  import pcs_40g_pkg::*;
#(
  parameter int AM_PERIOD = 16383
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        valid_i,
  input  logic [1:0]  head_i,
  input  logic [63:0] data_i,
  input  logic        block_lock_i,
  output logic        valid_o,
  output logic [1:0]  head_o,
  output logic [63:0] data_o,
  output logic        am_v_o,
  output logic        am_lock_o,
`ifdef PCS_40G_RX_BIP_EN
  output logic [1:0]  lane_id_o,
  output logic        bip_err_o
`else
  output logic [1:0]  lane_id_o
`endif
);

  localparam int               CNT_W    = (AM_PERIOD < 1) ? 1 : $clog2(AM_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(AM_PERIOD);
  localparam logic [1:0]       MM_LAST  = 2'(AM_MISMATCH_LIMIT - 1);

  am_state_t        r_state;
  am_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_mm;
  logic [1:0]       w_mm_nxt;
  logic [1:0]       r_lane;
  logic [1:0]       w_lane_nxt;
  logic             r_valid;
  logic [1:0]       r_head;
  logic [63:0]      r_data;
  logic             r_am_v;
  logic             w_am_v_nxt;
  logic             r_am_lock;

  logic             w_am_match;
  logic [1:0]       w_am_lane;
  logic [23:0]      w_key;
  logic [23:0]      w_inv;
  logic             w_check;
  logic             w_slot_ok;

  assign w_key = {data_i[7:0],   data_i[15:8],  data_i[23:16]};
  assign w_inv = {data_i[39:32], data_i[47:40], data_i[55:48]};

  pcs_40g_am_match u_am_match (
    .i_valid (valid_i),
    .i_head  (head_i),
    .i_key   (w_key),
    .i_inv   (w_inv),
    .o_match (w_am_match),
    .o_lane  (w_am_lane)
  );

  // The check slot is the first valid block once the countdown has expired.
  assign w_check   = valid_i && (r_cnt == {CNT_W{1'b0}}) && (r_state != ST_INIT);
  assign w_slot_ok = w_am_match && (w_am_lane == r_lane);

  // Next-state, counter, mismatch count and marker-slot strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mm_nxt    = r_mm;
    w_lane_nxt  = r_lane;
    w_am_v_nxt  = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_mm_nxt = 2'd0;
        if (w_am_match) begin
          w_lane_nxt  = w_am_lane;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = ST_WAIT_2ND;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_WAIT_2ND: begin
        if (w_check) begin
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = w_slot_ok ? ST_LOCKED : ST_INIT;
        end else if (valid_i) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_LOCKED: begin
        if (w_check) begin
          w_cnt_nxt  = CNT_LOAD;
          w_am_v_nxt = 1'b1;
          if (w_slot_ok) begin
            w_mm_nxt = 2'd0;
          end else if (r_mm == MM_LAST) begin
            w_mm_nxt    = 2'd0;
            w_state_nxt = ST_INIT;
          end else begin
            w_mm_nxt = r_mm + 2'd1;
          end
        end else if (valid_i) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_mm_nxt    = 2'd0;
      end
    endcase
    // Losing block lock wins over whatever the marker slot decided.
    if (!block_lock_i) begin
      w_state_nxt = ST_INIT;
      w_mm_nxt    = 2'd0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (nreset) begin
      r_state   <= ST_INIT;
      r_cnt     <= {CNT_W{1'b0}};
      r_mm      <= 2'd0;
      r_lane    <= 2'd0;
      r_valid   <= 1'b0;
      r_head    <= 2'b00;
      r_data    <= 64'd0;
      r_am_v    <= 1'b0;
      r_am_lock <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mm      <= w_mm_nxt;
      r_lane    <= w_lane_nxt;
      r_valid   <= valid_i;
      r_head    <= head_i;
      r_data    <= data_i;
      r_am_v    <= w_am_v_nxt;
      r_am_lock <= (w_state_nxt == ST_LOCKED);
    end
  end

  assign valid_o   = r_valid;
  assign head_o    = r_head;
  assign data_o    = r_data;
  assign am_v_o    = r_am_v;
  assign am_lock_o = r_am_lock;
  assign lane_id_o = r_lane;

`ifdef PCS_40G_RX_BIP_EN
  logic [7:0] r_bip;
  logic [7:0] w_bip_nxt;
  logic [7:0] w_bip_blk;
  logic       r_bip_err;
  logic       w_bip_err_nxt;

  assign w_bip_blk = bip8_contrib(head_i, data_i);

  // BIP accumulation; the marker itself seeds the next interval.
  always_comb begin
    w_bip_nxt     = r_bip;
    w_bip_err_nxt = 1'b0;
    if (r_state == ST_INIT) begin
      w_bip_nxt = w_am_match ? w_bip_blk : 8'h00;
    end else if (w_check) begin
      w_bip_nxt = w_bip_blk;
      if ((r_state == ST_LOCKED) && w_slot_ok && block_lock_i &&
          (r_bip != data_i[31:24])) begin
        w_bip_err_nxt = 1'b1;
      end else begin
        w_bip_err_nxt = 1'b0;
      end
    end else if (valid_i) begin
      w_bip_nxt = r_bip ^ w_bip_blk;
    end else begin
      w_bip_nxt = r_bip;
    end
  end

  // BIP accumulator and error pulse registers.
  always_ff @(posedge clk) begin
    if (nreset) begin
      r_bip     <= 8'h00;
      r_bip_err <= 1'b0;
    end else begin
      r_bip     <= w_bip_nxt;
      r_bip_err <= w_bip_err_nxt;
    end
  end

  assign bip_err_o = r_bip_err;
`endif

endmodule

// File: tb/tb_pcs_40g_rx_am_lock.sv
// Self-checking bench for pcs_40g_rx_am_lock with AM_PERIOD=15 (a marker
// every 16 valid blocks). A block-level reference model tracks lock mode,
// blocks seen since the last marker and the BIP over a queue of blocks.
module tb_pcs_40g_rx_am_lock;

  localparam int AM_PERIOD = 15;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        valid_i = 1'b0;
  logic [1:0]  head_i = 2'b00;
  logic [63:0] data_i = 64'd0;
  logic        block_lock_i = 1'b1;
  logic        valid_o;
  logic [1:0]  head_o;
  logic [63:0] data_o;
  logic        am_v_o;
  logic        am_lock_o;
  logic [1:0]  lane_id_o;
`ifdef PCS_40G_RX_BIP_EN
  logic        bip_err_o;
`endif

  pcs_40g_rx_am_lock #(.AM_PERIOD(AM_PERIOD)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .valid_i      (valid_i),
    .head_i       (head_i),
    .data_i       (data_i),
    .block_lock_i (block_lock_i),
    .valid_o      (valid_o),
    .head_o       (head_o),
    .data_o       (data_o),
    .am_v_o       (am_v_o),
    .am_lock_o    (am_lock_o),
`ifdef PCS_40G_RX_BIP_EN
    .lane_id_o    (lane_id_o),
    .bip_err_o    (bip_err_o)
`else
    .lane_id_o    (lane_id_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Marker bytes M0, M1, M2 per lane.
  logic [7:0] tbl [4][3] = '{'{8'h90, 8'h76, 8'h47}, '{8'hF0, 8'hC4, 8'hE6},
                             '{8'hC5, 8'h65, 8'h9B}, '{8'hA2, 8'h79, 8'h3D}};

  // Reference model: 0 hunting, 1 confirming, 2 locked.
  int          m_mode = 0;
  int          m_since = 0;
  int          m_miss = 0;
  logic [1:0]  m_lane = 2'd0;
  logic [65:0] m_q[$];
  logic        e_valid, e_lock, e_amv, e_dc, e_bip;
  logic [1:0]  e_head, e_lane;
  logic [63:0] e_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_marker(input logic v, input logic [1:0] h,
                                   input logic [63:0] d, output logic [1:0] ln);
    ln = 2'd0;
    if (!v || h != 2'b10) return 1'b0;
    for (int l = 0; l < 4; l++) begin
      if (d[7:0] == tbl[l][0] && d[15:8] == tbl[l][1] && d[23:16] == tbl[l][2] &&
          d[39:32] == ~tbl[l][0] && d[47:40] == ~tbl[l][1] && d[55:48] == ~tbl[l][2]) begin
        ln = 2'(l);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // BIP-8 over all queued blocks, bit by bit.
  function automatic logic [7:0] bip_of_queue();
    logic [7:0] b;
    b = 8'h00;
    foreach (m_q[i]) begin
      for (int j = 0; j < 8; j++)
        for (int k = 0; k < 8; k++)
          b[j] = b[j] ^ m_q[i][8*k + j];
      b[3] = b[3] ^ m_q[i][64];
      b[4] = b[4] ^ m_q[i][65];
    end
    return b;
  endfunction

  function automatic bit at_slot();
    return (m_mode != 0) && (m_since == AM_PERIOD);
  endfunction

  task automatic step(input logic v, input logic [1:0] h, input logic [63:0] d,
                      input logic bl, input logic rs);
    logic [1:0] ml;
    bit am, slot, good, was_locked;
    valid_i = v; head_i = h; data_i = d; block_lock_i = bl; nreset = rs;
    e_bip = 1'b0; e_amv = 1'b0; e_dc = 1'b0;
    if (rs) begin
      m_mode = 0; m_since = 0; m_miss = 0; m_lane = 2'd0; m_q.delete();
      e_valid = 1'b0; e_head = 2'b00; e_data = 64'd0; e_lock = 1'b0;
    end else begin
      e_valid = v; e_head = h; e_data = d;
      am = is_marker(v, h, d, ml);
      slot = v && at_slot();
      was_locked = (m_mode == 2);
      if (m_mode == 0) begin
        m_q.delete();
        if (am) begin
          m_mode = 1; m_lane = ml; m_since = 0; m_q.push_back({h, d});
        end
      end else if (v) begin
        if (slot) begin
          good = am && (ml == m_lane);
          if (m_mode == 2 && good && bl) e_bip = (bip_of_queue() != d[31:24]);
          if (m_mode == 1) m_mode = good ? 2 : 0;
          else if (good) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss == 4) m_mode = 0;
          end
          m_since = 0;
          m_q.delete();
          m_q.push_back({h, d});
        end else begin
          m_since++;
          m_q.push_back({h, d});
        end
      end
      if (!bl) m_mode = 0;
      if (m_mode == 0) m_miss = 0;
      e_lock = (m_mode == 2);
      e_amv  = slot && was_locked && e_lock;
      e_dc   = slot && (was_locked != e_lock);
    end
    e_lane = m_lane;
    @(posedge clk);
    #1;
    chk("valid_o", 64'(valid_o), 64'(e_valid));
    chk("head_o", 64'(head_o), 64'(e_head));
    chk("data_o", data_o, e_data);
    chk("am_lock_o", 64'(am_lock_o), 64'(e_lock));
    chk("lane_id_o", 64'(lane_id_o), 64'(e_lane));
    if (!e_dc) chk("am_v_o", 64'(am_v_o), 64'(e_amv));
`ifdef PCS_40G_RX_BIP_EN
    chk("bip_err_o", 64'(bip_err_o), 64'(e_bip));
`endif
  endtask

  task automatic send_data(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, ($urandom_range(1) == 1) ? 2'b01 : 2'b10, {$urandom, $urandom}, 1'b1, 1'b0);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 2'b10, {$urandom, $urandom}, 1'b1, 1'b0);
  endtask

  task automatic send_am(input int lane, input bit corrupt, input bit flip_bip);
    logic [63:0] d;
    logic [7:0]  b;
    int          bsel, bidx;
    b = bip_of_queue();
    if (flip_bip) b = b ^ 8'h10;
    d = {~b, ~tbl[lane][2], ~tbl[lane][1], ~tbl[lane][0], b, tbl[lane][2], tbl[lane][1], tbl[lane][0]};
    if (corrupt) begin
      bsel = $urandom_range(5);
      bidx = 8 * ((bsel < 3) ? bsel : bsel + 1) + $urandom_range(7);
      d[bidx] = ~d[bidx];
    end
    step(1'b1, 2'b10, d, 1'b1, 1'b0);
  endtask

  initial begin
    int r, sel;
    // Reset state
    repeat (3) step(1'b0, 2'b00, 64'd0, 1'b1, 1'b1);
    chk("rst_am_lock", 64'(am_lock_o), 64'd0);
    chk("rst_am_v", 64'(am_v_o), 64'd0);
    chk("rst_lane", 64'(lane_id_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);

    // Lane 2 acquisition
    send_data(3);
    send_am(2, 0, 0);
    chk("lock_after_1st", 64'(am_lock_o), 64'd0);
    send_data(15);
    send_am(2, 0, 0);
    chk("lock_after_2nd", 64'(am_lock_o), 64'd1);
    chk("lane_after_lock", 64'(lane_id_o), 64'd2);
    for (int i = 0; i < 2; i++) begin
      send_data(15);
      send_am(2, 0, 0);
      chk("am_v_locked", 64'(am_v_o), 64'd1);
    end

    // Three bad slots then a good one keep lock; four bad slots drop it
    for (int i = 0; i < 3; i++) begin
      send_data(15);
      send_am(2, 1, 0);
      chk("am_v_bad_slot", 64'(am_v_o), 64'd1);
    end
    send_data(15);
    send_am(2, 0, 0);
    chk("lock_held_3bad", 64'(am_lock_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      send_data(15);
      send_am(2, 1, 0);
      chk("lock_vs_bad_slots", 64'(am_lock_o), (i < 3) ? 64'd1 : 64'd0);
    end

    // Lane 1 followed by lane 3 at the check slot
    send_data(4);
    send_am(1, 0, 0);
    send_data(15);
    send_am(3, 0, 0);
    chk("lane_change_nolock", 64'(am_lock_o), 64'd0);
    send_data(15);
    send_am(3, 0, 0);
    chk("lane_change_rehunt", 64'(am_lock_o), 64'd0);
    send_data(15);
    send_am(3, 0, 0);
    chk("lane3_lock", 64'(am_lock_o), 64'd1);
    chk("lane3_id", 64'(lane_id_o), 64'd3);

    // Invalid gap shifts the slot
    send_data(7);
    send_idle(5);
    send_data(8);
    send_am(3, 0, 0);
    chk("gap_am_v", 64'(am_v_o), 64'd1);
    chk("gap_lock", 64'(am_lock_o), 64'd1);

    // Block lock loss for one cycle
    send_data(6);
    step(1'b1, 2'b01, {$urandom, $urandom}, 1'b0, 1'b0);
    chk("blk_lock_drop", 64'(am_lock_o), 64'd0);
    send_data(8);
    send_am(3, 0, 0);
    chk("blk_relock_1st", 64'(am_lock_o), 64'd0);
    send_data(15);
    send_am(3, 0, 0);
    chk("blk_relock_2nd", 64'(am_lock_o), 64'd1);

    // Reset for one cycle mid-lock
    send_data(6);
    step(1'b1, 2'b01, {$urandom, $urandom}, 1'b1, 1'b1);
    chk("rst_mid_lock", 64'(am_lock_o), 64'd0);
    send_data(8);
    send_am(3, 0, 0);
    chk("rst_relock_1st", 64'(am_lock_o), 64'd0);
    send_data(15);
    send_am(3, 0, 0);
    chk("rst_relock_2nd", 64'(am_lock_o), 64'd1);

`ifdef PCS_40G_RX_BIP_EN
    send_data(15);
    send_am(3, 0, 0);
    chk("bip_ok", 64'(bip_err_o), 64'd0);
    send_data(15);
    send_am(3, 0, 1);
    chk("bip_bad_pulse", 64'(bip_err_o), 64'd1);
    chk("bip_bad_am_v", 64'(am_v_o), 64'd1);
    send_data(1);
    chk("bip_pulse_single", 64'(bip_err_o), 64'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(99);
      if (r < 2) begin
        step(1'b1, 2'b01, {$urandom, $urandom}, 1'b0, 1'b0);
      end else if (r < 8) begin
        send_idle(1);
      end else if (at_slot()) begin
        sel = $urandom_range(9);
        if (sel < 7) send_am(int'(m_lane), 0, ($urandom_range(3) == 0));
        else if (sel == 7) send_am(int'(m_lane + 2'd1), 0, 0);
        else send_am(int'(m_lane), 1, 0);
      end else if (r < 11) begin
        send_am($urandom_range(3), 0, 0);
      end else begin
        send_data(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcs_40g_rx_am_lock.md
PCS_40G_RX_AM_LOCK -- requirements
Module: pcs_40g_rx_am_lock

Interface
REQ-001 SHALL have parameter AM_PERIOD, default 16383, meaning valid blocks between consecutive alignment markers on one lane.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port nreset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  a 66b block is present this cycle.
REQ-005 SHALL have port head_i  input  2  sync header of the input block.
REQ-006 SHALL have port data_i  input  64  block payload, byte 0 in data_i[7:0].
REQ-007 SHALL have port block_lock_i  input  1  66b block lock from the upstream block-sync stage.
REQ-008 SHALL have port valid_o  output  1  registered copy of valid_i.
REQ-009 SHALL have port head_o  output  2  registered copy of head_i.
REQ-010 SHALL have port data_o  output  64  registered copy of data_i.
REQ-011 SHALL have port am_v_o  output  1  the output block is an alignment marker slot and am_lock_o=1.
REQ-012 SHALL have port am_lock_o  output  1  alignment marker lock achieved.
REQ-013 SHALL have port lane_id_o  output  2  PCS lane number decoded from the locked marker.
REQ-014 SHALL have port bip_err_o  output  1  one-cycle BIP-8 mismatch pulse, present only with PCS_40G_RX_BIP_EN.

Function
REQ-015 SHALL detect a marker when valid_i=1, head_i=2'b10, and bytes {0,1,2,4,5,6} equal lane pattern {M0,M1,M2,~M0,~M1,~M2}: lane0 90/76/47, lane1 F0/C4/E6, lane2 C5/65/9B, lane3 A2/79/3D (hex); bytes 3 and 7 are ignored.
REQ-016 SHALL register valid/head/data with exactly 1-cycle latency, unmodified, in every state.
REQ-017 SHALL implement states INIT, WAIT_2ND and LOCKED.
REQ-018 SHALL, in INIT, on any marker: latch lane id, load the block counter with AM_PERIOD, and go to WAIT_2ND.
REQ-019 SHALL decrement the block counter only on valid_i=1 and non-marker-check blocks; the check slot is the valid block arriving when the counter is 0.
REQ-020 SHALL, in WAIT_2ND at the check slot: a marker of the latched lane sets am_lock_o=1 and goes to LOCKED; anything else returns to INIT.
REQ-021 SHALL, in LOCKED at each check slot: a match clears the mismatch count; a mismatch increments it; the 4th consecutive mismatch goes to INIT with am_lock_o=0 on the next cycle.
REQ-022 SHALL reload the counter with AM_PERIOD at every check slot, matched or not.
REQ-023 SHALL hold lane_id_o constant while in WAIT_2ND and LOCKED; a marker of another lane at the check slot counts as a mismatch.
REQ-024 SHALL force INIT, clearing the mismatch count, on the cycle after block_lock_i=0, overriding any simultaneous match.
REQ-025 SHALL assert am_v_o with the output copy of every check-slot block while in LOCKED, including mismatched slots.
REQ-026 SHALL ignore markers outside check slots while in WAIT_2ND and LOCKED.

Reset
REQ-027 SHALL, while nreset=1, clear state to INIT and set valid_o, head_o, data_o, am_v_o, am_lock_o, lane_id_o, bip_err_o, counter and mismatch count to 0.
REQ-028 SHALL return to INIT on reset asserted mid-lock; lock is reacquired only after two markers.

Configuration
REQ-029 SHALL compile BIP-8 checking only when macro PCS_40G_RX_BIP_EN is defined; without it, there is no bip_err_o port and no BIP logic.
REQ-030 SHALL, with the macro defined, accumulate BIP bit j as XOR of data_i[8k+j] for all k, plus head_i[0] into bit 3 and head_i[1] into bit 4, over each valid block.
REQ-031 SHALL, in LOCKED at a matched check slot, compare the accumulator, covering blocks since the previous marker and including it, with data_i[31:24], and pulse bip_err_o with the output block on inequality.
REQ-032 SHALL restart the accumulator with the marker block's own contribution at each check slot, and clear it in INIT.

Structure
REQ-033 SHALL place the lane marker byte table, the marker sync header constant, the state enum and the mismatch limit (4) in a shared pcs_40g package.
REQ-034 SHALL implement marker pattern matching as sub-module pcs_40g_am_match, combinational, outputting match and a 2-bit lane id.

Verification
REQ-035 SHALL verify: AM_PERIOD=15, lane2 markers every 16 valid blocks -> am_lock_o=1 one cycle after 2nd marker, lane_id_o=2, am_v_o on every later marker.
REQ-036 SHALL verify: locked, 3 corrupted markers then a good one -> lock held; 4 corrupted -> am_lock_o=0 one cycle after the 4th slot.
REQ-037 SHALL verify: lane1 marker then lane3 marker at check slot -> INIT, am_lock_o stays 0.
REQ-038 SHALL verify: locked, valid_i low 5 cycles mid-period -> check slot shifts 5 cycles, lock kept.
REQ-039 SHALL verify: locked, block_lock_i=0 or nreset=1 for one cycle -> am_lock_o=0 next cycle; two markers needed to relock.
REQ-040 SHALL verify, with PCS_40G_RX_BIP_EN: correct BIP3 -> bip_err_o=0; BIP3 with one bit flipped -> single bip_err_o pulse aligned with am_v_o.
